// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keying decoder and its companions.
//   - state encoding of the decoder FSM
//   - default timing values: 1 ms prescaler terminal count at 50 MHz,
//     glitch, dot/dash and end-of-frame thresholds, all in ms
//   - the SOS frame as decoded (dot = 0, dash = 1, first element in bit 0)
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] T1MS_50M   = 16'd49_999;
    localparam logic [9:0]  GLITCH_MS  = 10'd20;
    localparam logic [9:0]  DOT_MAX_MS = 10'd200;
    localparam logic [9:0]  GAP_END_MS = 10'd200;

    // dot dot dot dash dash dash dot dot dot
    localparam logic [15:0] SOS_CODE = 16'h0038;
    localparam logic [4:0]  SOS_LEN  = 5'd9;

    localparam logic [9:0]  MS_MAX   = 10'd1023;
    localparam logic [4:0]  MAX_LEN  = 5'd16;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..T1MS and flags the terminal cycle.
//   clk  : system clock
//   srst : synchronous active-high reset
//   clr  : synchronous restart of the count (used to re-align to key edges)
//   tick : high for one cycle while the count sits at T1MS
module ms_tick_gen
    import morse_pkg::*;
#(
    parameter logic [15:0] T1MS = T1MS_50M
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    output logic tick
);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == T1MS) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign tick = (cnt_reg == T1MS);

endmodule

// File: rtl/morse_key_decoder.sv
// Morse keying decoder: times marks and spaces in ms, builds a frame of
// dot/dash elements and reports it once a long enough space ends the frame.
//   CLK         : 50 MHz system clock
//   RST         : synchronous active-high reset
//   En_Sig      : decoder enable; low forces idle and drops a partial frame
//   Pin_In      : asynchronous keying level, high = mark
//   Frame_Valid : one-cycle pulse, Frame_Code/Frame_Len updated
//   Frame_Code  : element i in bit i, 1 = dash, 0 = dot
//   Frame_Len   : number of elements, 1..16
//   Sos_Det     : one-cycle pulse with Frame_Valid when the frame is SOS
//   Overflow    : one-cycle pulse ending a frame of more than 16 elements
module morse_key_decoder #(
    parameter logic [15:0] T1MS       = morse_pkg::T1MS_50M,
    parameter logic [9:0]  GLITCH_MS  = morse_pkg::GLITCH_MS,
    parameter logic [9:0]  DOT_MAX_MS = morse_pkg::DOT_MAX_MS,
    parameter logic [9:0]  GAP_END_MS = morse_pkg::GAP_END_MS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        En_Sig,
    input  logic        Pin_In,
    output logic        Frame_Valid,
    output logic [15:0] Frame_Code,
    output logic [4:0]  Frame_Len,
    output logic        Sos_Det,
    output logic        Overflow
);

    import morse_pkg::*;

    logic        sync1_reg;
    logic        key_reg;
    state_t      state_reg;
    logic [9:0]  count_ms_reg;
    logic [15:0] code_reg;
    logic [4:0]  len_reg;
    logic        ovf_reg;

    logic        tick;
    logic        leave;
    logic [9:0]  ms_now;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            key_reg   <= 1'b0;
        end else begin
            sync1_reg <= Pin_In;
            key_reg   <= sync1_reg;
        end
    end

    // High whenever the FSM is about to change state (or is held idle by
    // the enable); both the prescaler and the ms counter restart then, so
    // every mark and space is timed from its own starting edge.
    always_comb begin
        leave = 1'b0;
        if (!En_Sig) begin
            leave = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE:  leave = key_reg;
                ST_MARK:  leave = !key_reg;
                ST_SPACE: leave = key_reg || (count_ms_reg == GAP_END_MS);
                ST_DONE:  leave = 1'b1;
            endcase
        end
    end

    // Mark length including a tick landing on the release cycle, so a mark
    // of N whole ms classifies as N rather than N-1.
    assign ms_now = (tick && (count_ms_reg != MS_MAX)) ? count_ms_reg + 10'd1
                                                       : count_ms_reg;

    ms_tick_gen #(
        .T1MS(T1MS)
    ) u_tick (
        .clk (CLK),
        .srst(RST),
        .clr (leave),
        .tick(tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            count_ms_reg <= '0;
            code_reg     <= '0;
            len_reg      <= '0;
            ovf_reg      <= 1'b0;
            Frame_Valid  <= 1'b0;
            Frame_Code   <= '0;
            Frame_Len    <= '0;
            Sos_Det      <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            Frame_Valid <= 1'b0;
            Sos_Det     <= 1'b0;
            Overflow    <= 1'b0;

            if (leave) begin
                count_ms_reg <= '0;
            end else if (tick && (count_ms_reg != MS_MAX)) begin
                count_ms_reg <= count_ms_reg + 10'd1;
            end

            if (!En_Sig) begin
                state_reg <= ST_IDLE;
                code_reg  <= '0;
                len_reg   <= '0;
                ovf_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (key_reg) begin
                            state_reg <= ST_MARK;
                        end
                    end
                    ST_MARK: begin
                        if (!key_reg) begin
                            if (ms_now < GLITCH_MS) begin
                                // Glitch: the gap count restarts from here.
                                state_reg <= (len_reg == 5'd0) ? ST_IDLE : ST_SPACE;
                            end else begin
                                if (len_reg == MAX_LEN) begin
                                    ovf_reg <= 1'b1;
                                end else begin
                                    code_reg[len_reg[3:0]] <= (ms_now >= DOT_MAX_MS);
                                    len_reg                <= len_reg + 5'd1;
                                end
                                state_reg <= ST_SPACE;
                            end
                        end
                    end
                    ST_SPACE: begin
                        if (key_reg) begin
                            state_reg <= ST_MARK;
                        end else if (count_ms_reg == GAP_END_MS) begin
                            state_reg <= ST_DONE;
                            if (ovf_reg) begin
                                Overflow <= 1'b1;
                            end else begin
                                Frame_Valid <= 1'b1;
                                Frame_Code  <= code_reg;
                                Frame_Len   <= len_reg;
                                Sos_Det     <= (len_reg == SOS_LEN) && (code_reg == SOS_CODE);
                            end
                        end
                    end
                    ST_DONE: begin
                        code_reg  <= '0;
                        len_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder with a 10-cycle millisecond (T1MS = 9).
// A duration-level model turns the keying waveform into expected frames
// and is compared against the DUT outputs every cycle; a set of literal
// expectations per scenario pins the model down.
module tb_morse_key_decoder;

    localparam int CYC_PER_MS = 10;
    localparam int END_LAT    = 200 * CYC_PER_MS + 3;

    logic        CLK    = 1'b0;
    logic        RST    = 1'b1;
    logic        En_Sig = 1'b1;
    logic        Pin_In = 1'b0;
    logic        Frame_Valid;
    logic [15:0] Frame_Code;
    logic [4:0]  Frame_Len;
    logic        Sos_Det;
    logic        Overflow;

    always #5 CLK = ~CLK;

    morse_key_decoder #(
        .T1MS(16'd9)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .En_Sig     (En_Sig),
        .Pin_In     (Pin_In),
        .Frame_Valid(Frame_Valid),
        .Frame_Code (Frame_Code),
        .Frame_Len  (Frame_Len),
        .Sos_Det    (Sos_Det),
        .Overflow   (Overflow)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // model of the frame being keyed
    int          cyc      = 0;
    logic        prev_pin = 1'b0;
    int          rise_cyc = 0;
    int          m_len    = 0;
    logic [15:0] m_code   = '0;
    bit          m_ovf    = 1'b0;
    int          end_cyc  = -1;
    logic [15:0] out_code = '0;
    logic [4:0]  out_len  = '0;
    bit          e_fv, e_ov, e_sos;
    int          ms;

    // what the DUT actually reported
    int          n_valid   = 0;
    int          n_ovf     = 0;
    logic [15:0] last_code = '0;
    logic [4:0]  last_len  = '0;
    bit          last_sos  = 1'b0;

    // literal-expectation requests from the stimulus process
    string       lit_name;
    logic [31:0] lit_got, lit_exp;
    int          lit_seq  = 0;
    int          lit_done = 0;

    always @(posedge CLK) begin
        cyc++;
        e_fv = 1'b0;
        e_ov = 1'b0;
        e_sos = 1'b0;
        if (RST) begin
            m_len = 0; m_code = '0; m_ovf = 1'b0; end_cyc = -1;
            out_code = '0; out_len = '0; prev_pin = 1'b0;
        end else if (!En_Sig) begin
            m_len = 0; m_code = '0; m_ovf = 1'b0; end_cyc = -1;
            prev_pin = 1'b0;
        end else begin
            if (cyc == end_cyc) begin
                end_cyc = -1;
                if (m_ovf) begin
                    e_ov = 1'b1;
                end else begin
                    e_fv     = 1'b1;
                    out_code = m_code;
                    out_len  = 5'(m_len);
                    // S O S = three dots, three dashes, three dots
                    e_sos    = (m_len == 9) && (m_code == 16'b0000_0000_0011_1000);
                end
                m_len = 0; m_code = '0; m_ovf = 1'b0;
            end
            if (Pin_In && !prev_pin) begin
                rise_cyc = cyc;
                end_cyc  = -1;
            end
            if (!Pin_In && prev_pin) begin
                ms = (cyc - rise_cyc) / CYC_PER_MS;
                if (ms >= 20) begin
                    if (m_len == 16) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_code[m_len] = (ms >= 200);
                        m_len++;
                    end
                end
                if (m_len > 0) end_cyc = cyc + END_LAT;
            end
            prev_pin = Pin_In;
        end

        #1;
        chk_cnt++;
        if ({Frame_Valid, Overflow, Sos_Det, Frame_Code, Frame_Len} ===
            {e_fv, e_ov, e_sos, out_code, out_len}) begin
            pass_cnt++;
        end else begin
            $display("FAIL cycle %0d: got fv=%b ov=%b sos=%b code=%h len=%0d, expected fv=%b ov=%b sos=%b code=%h len=%0d",
                     cyc, Frame_Valid, Overflow, Sos_Det, Frame_Code, Frame_Len,
                     e_fv, e_ov, e_sos, out_code, out_len);
        end
        if (Frame_Valid === 1'b1) begin
            n_valid++;
            last_code = Frame_Code;
            last_len  = Frame_Len;
            last_sos  = Sos_Det;
            $display("frame: len=%0d code=%h sos=%b at cycle %0d", Frame_Len, Frame_Code, Sos_Det, cyc);
        end
        if (Overflow === 1'b1) begin
            n_ovf++;
            $display("overflow at cycle %0d", cyc);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            chk_cnt++;
            if (lit_got === lit_exp) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %0h, expected %0h", lit_name, lit_got, lit_exp);
            end
        end
    end

    task automatic wait_ms(input int n);
        repeat (n * CYC_PER_MS) @(negedge CLK);
    endtask

    task automatic mark(input int n);
        Pin_In = 1'b1;
        wait_ms(n);
        Pin_In = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        lit_name = name;
        lit_got  = got;
        lit_exp  = exp;
        lit_seq++;
        @(negedge CLK);
    endtask

    int base_v, base_o;

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        lit("reset_code", 32'(Frame_Code), 32'h0);
        wait_ms(2);

        // SOS as the buzzer sequencer keys it
        base_v = n_valid;
        for (int i = 0; i < 9; i++) begin
            mark((i >= 3 && i <= 5) ? 300 : 100);
            if (i < 8) wait_ms(50);
        end
        wait_ms(205);
        lit("sos_frames", 32'(n_valid - base_v), 32'd1);
        lit("sos_len", 32'(last_len), 32'd9);
        lit("sos_code", 32'(last_code), 32'h0038);
        lit("sos_det", 32'(last_sos), 32'd1);

        // dot/dash boundary
        mark(199);
        wait_ms(205);
        lit("m199_len", 32'(last_len), 32'd1);
        lit("m199_code", 32'(last_code), 32'h0);
        lit("m199_sos", 32'(last_sos), 32'd0);
        mark(200);
        wait_ms(205);
        lit("m200_code", 32'(last_code), 32'h1);

        // lone glitch: nothing reported
        base_v = n_valid;
        mark(10);
        wait_ms(30);
        lit("glitch_frames", 32'(n_valid - base_v), 32'd0);

        // glitch after a dot-dot frame: frame end timed from the glitch
        mark(30); wait_ms(50);
        mark(30); wait_ms(50);
        mark(10);
        wait_ms(205);
        lit("dotdot_len", 32'(last_len), 32'd2);
        lit("dotdot_code", 32'(last_code), 32'h0);

        // 17 dots overflow, then a normal frame
        base_v = n_valid;
        base_o = n_ovf;
        for (int i = 0; i < 17; i++) begin
            mark(25);
            if (i < 16) wait_ms(30);
        end
        wait_ms(205);
        lit("ovf_pulses", 32'(n_ovf - base_o), 32'd1);
        lit("ovf_frames", 32'(n_valid - base_v), 32'd0);
        lit("ovf_keeps_code", 32'(last_code), 32'h0);
        mark(100);
        wait_ms(205);
        lit("post_ovf_frames", 32'(n_valid - base_v), 32'd1);
        lit("post_ovf_len", 32'(last_len), 32'd1);

        // enable dropped mid-frame
        base_v = n_valid;
        for (int i = 0; i < 4; i++) begin
            mark(25);
            wait_ms(30);
        end
        En_Sig = 1'b0;
        repeat (2) @(negedge CLK);
        En_Sig = 1'b1;
        wait_ms(5);
        mark(300);
        wait_ms(205);
        lit("en_frames", 32'(n_valid - base_v), 32'd1);
        lit("en_len", 32'(last_len), 32'd1);
        lit("en_code", 32'(last_code), 32'h1);

        // reset mid-mark
        base_v = n_valid;
        Pin_In = 1'b1;
        wait_ms(100);
        RST = 1'b1;
        Pin_In = 1'b0;
        repeat (3) @(negedge CLK);
        lit("rst_code", 32'(Frame_Code), 32'h0);
        lit("rst_len", 32'(Frame_Len), 32'h0);
        RST = 1'b0;
        wait_ms(205);
        lit("rst_frames", 32'(n_valid - base_v), 32'd0);

        // stuck key saturates the ms counter and still counts as a dash
        mark(1030);
        wait_ms(205);
        lit("hold_len", 32'(last_len), 32'd1);
        lit("hold_code", 32'(last_code), 32'h1);

        @(negedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Receives an on/off Morse keying signal and decodes it into a frame of dot/dash elements: a buzzer-drive level looped back, or a debounced key. Mark and space lengths are timed in milliseconds from a 50 MHz clock. At end of frame it outputs the element pattern and its length, and flags the SOS pattern (three dots, three dashes, three dots). It is the receive-side counterpart of the SOS buzzer sequencer and is used to self-check that sequencer and to decode user keying from the KEY inputs.

## Interface
- T1MS, 16'd49_999, prescaler terminal count (50 MHz × 1 ms − 1)
- GLITCH_MS, 10'd20, marks shorter than this are discarded
- DOT_MAX_MS, 10'd200, marks shorter than this are dots; marks this long or longer are dashes
- GAP_END_MS, 10'd200, a space reaching this length ends the frame
- CLK  input  1  system clock, 50 MHz
- RST  input  1  reset, synchronous, active-high
- En_Sig  input  1  decoder enable; low forces idle and discards the partial frame
- Pin_In  input  1  keying level, high = mark; asynchronous, synchronised internally
- Frame_Valid  output  1  one-cycle pulse: Frame_Code and Frame_Len are valid
- Frame_Code  output  16  element i in bit i (first element in bit 0); 1 = dash, 0 = dot; unused bits 0
- Frame_Len  output  5  number of elements, 1..16
- Sos_Det  output  1  one-cycle pulse, coincident with Frame_Valid, when the frame is SOS
- Overflow  output  1  one-cycle pulse at end of a frame with more than 16 elements

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0, 2-flop synchroniser 0.
- Pin_In passes through a 2-flop synchroniser to give `key`; every behaviour below uses `key`.
- ms tick: the prescaler counts 0..T1MS and pulses a tick at T1MS. The prescaler and Count_MS clear on every state transition.
- Count_MS is a 10-bit counter that increments on each tick and saturates at 1023.
- IDLE: wait for `key`=1, then go to MARK. The element shift register and length are already clear.
- MARK: on `key` falling, let ms = Count_MS.
  - ms < GLITCH_MS: discard the mark. Return to IDLE if len = 0, otherwise return to SPACE with a fresh gap count.
  - ms < DOT_MAX_MS: store a dot (0) at bit[len], then len++, then go to SPACE.
  - otherwise: store a dash (1), then len++, then go to SPACE. A saturated (stuck) key counts as a dash.
  - When len is already 16, do not store the element and set the sticky ovf flag.
- SPACE: `key`=1 goes to MARK. When Count_MS reaches GAP_END_MS, go to DONE.
- DONE (one cycle):
  - If ovf is set, pulse Overflow.
  - Otherwise pulse Frame_Valid and drive Frame_Code/Frame_Len.
  - Sos_Det = (len = 9 && code = 16'h0038).
  - Then clear code, len and ovf, and go to IDLE.
- Frame_Code and Frame_Len hold their value until the next DONE.
- En_Sig low: from any state, in the next cycle go to IDLE, clear code/len/ovf and counters, and emit no pulse. A frame in progress is lost.
- RST mid-frame: same as the reset values above; no pulse is emitted.

## Timing
- Durations are measured in whole ms: the prescaler restarts at each edge, so ±1 ms quantisation plus the 2-cycle synchroniser delay.
- Frame_Valid and Sos_Det assert on the cycle after the tick that makes Count_MS = GAP_END_MS. That is (GAP_END_MS × (T1MS+1)) + 3 cycles after the Pin_In falling edge of the last mark.
- Pulses are exactly 1 cycle wide. Frame_Valid and Overflow are mutually exclusive.
- With the SOS sequencer timing (dot 100 ms, dash 300 ms, gap 50 ms), every mark classifies unambiguously and no frame ends mid-pattern.

## Structure
- Shared package (morse_pkg) holds:
  - state encodings IDLE/MARK/SPACE/DONE
  - default values T1MS_50M, GLITCH_MS, DOT_MAX_MS, GAP_END_MS
  - SOS_CODE = 16'h0038, SOS_LEN = 5'd9
- Sub-module ms_tick_gen: prescaler with a clear input and a one-cycle tick output, parameter T1MS. It is reusable by the buzzer sequencer.
- The FSM, Count_MS, the element shift register and the output registers live in the top module.

## Test plan
For simulation, set T1MS=9 (1 ms = 10 cycles) and keep the other parameters at their defaults.
- SOS sequencer pattern on Pin_In (100/50/300 ms marks and gaps), then idle → one Frame_Valid, Frame_Len=9, Frame_Code=16'h0038, Sos_Det=1.
- Single 300 ms mark, then idle → Frame_Len=1, Frame_Code=16'h0001, Sos_Det=0. Single 199 ms mark → Frame_Code=0; single 200 ms mark → Frame_Code=1.
- 10 ms pulse alone → no Frame_Valid, state returns to IDLE. A 10 ms pulse inside the gaps of a dot-dot frame → Frame_Len=2 and the frame end is timed from the glitch.
- 17 dots separated by 50 ms gaps → Overflow pulse once, no Frame_Valid; a following normal frame decodes correctly.
- En_Sig dropped after 4 elements, raised again, then one dash sent → Frame_Len=1, Frame_Code=1. A synchronous RST pulse mid-mark → all outputs 0, no pulse.
- Key held high for 2 s → Count_MS saturates at 1023; on release a dash is recorded, Frame_Len=1.
